// File: rtl/serpent_xts_pkg.sv
// Shared types and helpers for the XTS sequencer: FSM states, widths, byte-order and tweak arithmetic.
package serpent_xts_pkg;
   localparam int BLK_W = 128;
   localparam int KEY_W = 256;
   localparam logic [7:0] XTS_POLY = 8'h87;

   typedef enum logic [2:0] {
      S_IDLE, S_TWK_START, S_TWK_WAIT, S_BLK_IN, S_BLK_START, S_BLK_WAIT, S_BLK_OUT, S_DRAIN
   } xts_state_e;

   // Bus byte 0 sits in bits [127:120]; the little-endian integer has byte 0 in bits [7:0].
   function automatic logic [BLK_W-1:0] bus2le(input logic [BLK_W-1:0] b);
      logic [BLK_W-1:0] r;
      for (int i = 0; i < BLK_W/8; i++) r[8*i +: 8] = b[BLK_W-1-8*i -: 8];
      return r;
   endfunction

   function automatic logic [BLK_W-1:0] le2bus(input logic [BLK_W-1:0] x);
      return bus2le(x);
   endfunction

   function automatic logic [BLK_W-1:0] gf_mul_alpha(input logic [BLK_W-1:0] t);
      logic [BLK_W-1:0] x;
      x = bus2le(t);
      x = {x[BLK_W-2:0], 1'b0} ^ {{(BLK_W-8){1'b0}}, (x[BLK_W-1] ? XTS_POLY : 8'h00)};
      return le2bus(x);
   endfunction
endpackage

// File: rtl/xts_tweak_reg.sv
// Running XTS tweak T: loaded from the encrypted sector, stepped by alpha after each data block.
module xts_tweak_reg
   import serpent_xts_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [BLK_W-1:0] load_val,
   input  logic             upd,
   input  logic [BLK_W-1:0] a,
   input  logic [BLK_W-1:0] b,
   output logic [BLK_W-1:0] a_x,
   output logic [BLK_W-1:0] b_x
);
   logic [BLK_W-1:0] t;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    t <= '0;
      else if (load) t <= load_val;
      else if (upd)  t <= gf_mul_alpha(t);
   end

   assign a_x = a ^ t;
   assign b_x = b ^ t;
endmodule

// File: rtl/serpent_xts_ctrl.sv
// XTS sector sequencer: tweak = E(key2, sector), then one block at a time through the shared core under key1.
module serpent_xts_ctrl
   import serpent_xts_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int TO_W  = 10
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic             i_cmd_dec,
   input  logic [63:0]      i_cmd_sector,
   input  logic [CNT_W-1:0] i_cmd_count,
   input  logic [KEY_W-1:0] i_key1,
   input  logic [KEY_W-1:0] i_key2,
   input  logic             i_abort,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [BLK_W-1:0] i_in_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [BLK_W-1:0] o_out_data,
   output logic             o_done,
   output logic             o_err,
   output logic             o_core_key_valid,
   output logic             o_core_ena_en_de,
   output logic [KEY_W-1:0] o_core_key,
   output logic [BLK_W-1:0] o_core_data,
   input  logic [BLK_W-1:0] i_core_data,
   input  logic             i_core_data_valid
);
   // wdog counts cycles since the start pulse; expiry fires one short of all-ones so the pulse lands on it.
   localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   xts_state_e       state, state_n;
   logic [KEY_W-1:0] key1_r;
   logic             dec_r;
   logic [CNT_W-1:0] rem;
   logic [TO_W-1:0]  wdog;
   logic             cmd_acc, twk_res, blk_acc, blk_res, done_n, err_n, waiting;
   logic [BLK_W-1:0] pp, cc_x;

   xts_tweak_reg u_tweak (
      .clk(i_clk), .rst_n(i_rstn), .load(twk_res), .load_val(i_core_data), .upd(blk_res),
      .a(i_in_data), .b(i_core_data), .a_x(pp), .b_x(cc_x)
   );

   assign waiting = (state == S_TWK_WAIT) || (state == S_BLK_WAIT) || (state == S_DRAIN);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= S_IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      cmd_acc = 1'b0; twk_res = 1'b0; blk_acc = 1'b0; blk_res = 1'b0;
      done_n = 1'b0;  err_n = 1'b0;
      o_cmd_ready = 1'b0; o_in_ready = 1'b0; o_out_valid = 1'b0; o_core_key_valid = 1'b0;
      unique case (state)
         S_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) begin
               cmd_acc = 1'b1;
               if (i_cmd_count == '0) done_n = 1'b1;
               else                   state_n = S_TWK_START;
            end
         end
         S_TWK_START, S_BLK_START: begin
            o_core_key_valid = 1'b1;
            if (i_abort) state_n = S_IDLE;
            else         state_n = (state == S_TWK_START) ? S_TWK_WAIT : S_BLK_WAIT;
         end
         S_BLK_IN: begin
            o_in_ready = 1'b1;
            if (i_abort) state_n = S_IDLE;
            else if (i_in_valid) begin
               blk_acc = 1'b1;
               state_n = S_BLK_START;
            end
         end
         S_BLK_OUT: begin
            o_out_valid = 1'b1;
            if (i_abort) state_n = S_IDLE;
            else if (i_out_ready) begin
               done_n  = (rem == '0);
               state_n = (rem == '0) ? S_IDLE : S_BLK_IN;
            end
         end
         default: begin
            // a result coincident with abort, or any result while draining, is simply dropped
            if (i_core_data_valid) begin
               if (i_abort || state == S_DRAIN) state_n = S_IDLE;
               else if (state == S_TWK_WAIT) begin
                  twk_res = 1'b1;
                  state_n = S_BLK_IN;
               end else begin
                  blk_res = 1'b1;
                  state_n = S_BLK_OUT;
               end
            end else if (wdog == WD_LAST) begin
               err_n   = 1'b1;
               state_n = S_IDLE;
            end else if (i_abort) begin
               state_n = (state == S_DRAIN) ? S_IDLE : S_DRAIN;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         key1_r <= '0; dec_r <= 1'b0; rem <= '0; wdog <= '0;
         o_done <= 1'b0; o_err <= 1'b0; o_out_data <= '0;
         o_core_key <= '0; o_core_data <= '0; o_core_ena_en_de <= 1'b0;
      end else begin
         o_done <= done_n;
         o_err  <= err_n;
         if (cmd_acc) begin
            key1_r           <= i_key1;
            dec_r            <= i_cmd_dec;
            rem              <= i_cmd_count;
            o_core_key       <= i_key2;
            o_core_ena_en_de <= 1'b1;
            o_core_data      <= le2bus({{(BLK_W-64){1'b0}}, i_cmd_sector});
         end
         if (twk_res) begin
            o_core_key       <= key1_r;
            o_core_ena_en_de <= ~dec_r;
         end
         if (blk_acc) o_core_data <= pp;
         if (blk_res) begin
            o_out_data <= cc_x;
            rem        <= rem - CNT_W'(1);
         end
         if (o_core_key_valid) wdog <= TO_W'(1);
         else if (waiting)     wdog <= wdog + TO_W'(1);
      end
   end
endmodule

// File: tb/tb_serpent_xts_ctrl.sv
// Directed bench for serpent_xts_ctrl with a stand-in invertible core and an XTS scoreboard.
module tb_serpent_xts_ctrl;
   localparam int CNT_W    = 16;
   localparam int TO_W     = 4;
   localparam int CORE_LAT = 3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic cmd_valid, cmd_ready, cmd_dec, abort_i, in_valid, in_ready, out_valid, done, err;
   logic out_ready = 1'b0;
   logic [63:0] cmd_sector;
   logic [CNT_W-1:0] cmd_count;
   logic [255:0] key1, key2, core_key;
   logic [127:0] in_data, out_data, core_data;
   logic core_kv, core_en;
   logic core_dv = 1'b0;
   logic [127:0] core_din = '0;

   serpent_xts_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_dec(cmd_dec), .i_cmd_sector(cmd_sector), .i_cmd_count(cmd_count),
      .i_key1(key1), .i_key2(key2), .i_abort(abort_i),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_done(done), .o_err(err), .o_core_key_valid(core_kv), .o_core_ena_en_de(core_en),
      .o_core_key(core_key), .o_core_data(core_data),
      .i_core_data(core_din), .i_core_data_valid(core_dv)
   );

   int checks = 0, errors = 0, cyc = 0, starts = 0, done_cnt = 0, err_cnt = 0, last_start_cyc = 0;
   bit mute = 0, force_twk = 0, rdy_rand = 0;
   logic [127:0] force_val;
   logic [127:0] exp_q[$];
   logic [127:0] st_data[$];
   logic [255:0] st_key[$];
   logic st_en[$];
   logic [127:0] blk[8], res[8], pt[8];
   logic [255:0] k1, k2;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic tmo(input string tag);
      checks++;
      errors++;
      $error("FAIL %s bound expired (observed no event, expected one)", tag);
   endtask

   // Stand-in core: invertible keyed mix, encf/decf are exact inverses.
   function automatic logic [127:0] encf(input logic [255:0] k, input logic [127:0] x);
      logic [127:0] y;
      y = x ^ k[127:0];
      y = {y[114:0], y[127:115]};
      return y ^ k[255:128];
   endfunction

   function automatic logic [127:0] decf(input logic [255:0] k, input logic [127:0] y);
      logic [127:0] x;
      x = y ^ k[255:128];
      x = {x[12:0], x[127:13]};
      return x ^ k[127:0];
   endfunction

   function automatic logic [127:0] tweak_pt(input logic [63:0] s);
      logic [127:0] t;
      t = '0;
      for (int i = 0; i < 8; i++) t[127-8*i -: 8] = s[8*i +: 8];
      return t;
   endfunction

   // Byte-wise multiply by alpha: bus byte i is LE byte i, carry moves from byte i-1 into byte i.
   function automatic logic [127:0] alpha_tb(input logic [127:0] t);
      logic [7:0] b [16];
      logic [7:0] nb [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) b[i] = t[127-8*i -: 8];
      for (int i = 15; i > 0; i--) nb[i] = {b[i][6:0], b[i-1][7]};
      nb[0] = {b[0][6:0], 1'b0} ^ (b[15][7] ? 8'h87 : 8'h00);
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = nb[i];
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push_exp(input bit dec, input logic [63:0] sec, input int n, input int npush,
                           input logic [255:0] ka, input logic [255:0] kb,
                           input bit frc, input logic [127:0] fv);
      logic [127:0] t, c;
      t = frc ? fv : encf(kb, tweak_pt(sec));
      for (int i = 0; i < n; i++) begin
         c = (dec ? decf(ka, blk[i] ^ t) : encf(ka, blk[i] ^ t)) ^ t;
         res[i] = c;
         if (i < npush) exp_q.push_back(c);
         t = alpha_tb(t);
      end
   endtask

   // Core model: answers CORE_LAT cycles after a start pulse unless muted.
   logic [255:0] ck;
   logic [127:0] cd;
   logic ce;
   int ccnt = 0;
   bit cbusy = 0;
   always @(negedge clk) begin
      if (!rstn) begin
         core_dv = 1'b0;
         cbusy = 0;
      end else begin
         core_dv = 1'b0;
         if (cbusy) begin
            if (ccnt == 1) begin
               cbusy = 0;
               core_dv = 1'b1;
               check("core_key_stable", core_key, ck);
               check("core_data_stable", core_data, cd);
               check("core_en_stable", core_en, ce);
               if (force_twk) begin
                  core_din = force_val;
                  force_twk = 0;
               end else core_din = ce ? encf(ck, cd) : decf(ck, cd);
            end else ccnt--;
         end
         if (core_kv) begin
            ck = core_key; cd = core_data; ce = core_en;
            cbusy = !mute;
            ccnt = CORE_LAT;
            starts++;
            last_start_cyc = cyc;
            st_data.push_back(core_data);
            st_key.push_back(core_key);
            st_en.push_back(core_en);
         end
      end
   end

   // Output sink and scoreboard; also counts done/err pulses.
   bit stall_prev = 0;
   logic [127:0] held;
   always @(negedge clk) begin
      if (!rstn) begin
         out_ready = 1'b0;
         stall_prev = 0;
      end else begin
         if (out_valid && stall_prev) check("stall_stable", out_data, held);
         out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_out observed=%h expected=no output", out_data);
            end
            if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
         end
         stall_prev = out_valid && !out_ready;
         held = out_data;
         if (done) done_cnt++;
         if (err) err_cnt++;
      end
   end

   task automatic clear_log();
      starts = 0;
      st_data.delete();
      st_key.delete();
      st_en.delete();
   endtask

   task automatic send_cmd(input bit dec, input logic [63:0] sec, input int n,
                           input logic [255:0] ka, input logic [255:0] kb);
      int b = 0;
      @(negedge clk);
      while (!cmd_ready && b < 100) begin @(negedge clk); b++; end
      if (b >= 100) tmo("cmd_ready_wait");
      cmd_valid = 1'b1; cmd_dec = dec; cmd_sector = sec; cmd_count = CNT_W'(n);
      key1 = ka; key2 = kb;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic feed_one(input logic [127:0] d);
      int b = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = d;
      while (!in_ready && b < 200) begin @(negedge clk); b++; end
      if (b >= 200) tmo("in_ready_wait");
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int b = 0;
      while (!done && b < 1000) begin @(negedge clk); b++; end
      if (b >= 1000) tmo(tag);
      @(negedge clk);
   endtask

   task automatic run_cmd(input bit dec, input logic [63:0] sec, input int n,
                          input logic [255:0] ka, input logic [255:0] kb);
      send_cmd(dec, sec, n, ka, kb);
      for (int i = 0; i < n; i++) feed_one(blk[i]);
      wait_done("done_wait");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout reached (expected bench to finish)");
      $fatal(1, "bench time limit");
   end

   initial begin
      int d0, e0, b;
      cmd_valid = 0; cmd_dec = 0; cmd_sector = '0; cmd_count = '0; key1 = '0; key2 = '0;
      abort_i = 0; in_valid = 0; in_data = '0; force_val = '0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_core_kv", core_kv, 0);
      check("rst_core_en", core_en, 0);
      check("rst_core_key", core_key, 0);
      check("rst_core_data", core_data, 0);
      check("rst_out_data", out_data, 0);
      rstn = 1'b1;

      // zero-length command
      clear_log();
      send_cmd(0, 64'd5, 0, '0, '0);
      check("zero_done", done, 1);
      @(negedge clk);
      check("zero_done_pulse", done, 0);
      check("zero_cmd_ready", cmd_ready, 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      check("zero_no_start", starts, 0);

      // all-zero keys, sector 0, 4 blocks encrypt
      for (int i = 0; i < 4; i++) begin blk[i] = rnd256()[127:0]; pt[i] = blk[i]; end
      clear_log();
      push_exp(0, 64'd0, 4, 4, '0, '0, 0, '0);
      run_cmd(0, 64'd0, 4, '0, '0);
      @(posedge clk);
      check("enc0_starts", starts, 5);
      check("enc0_twk_en", st_en[0], 1);
      check("enc0_twk_data", st_data[0], 0);
      check("enc0_blk_en", st_en[1], 1);
      check("enc0_q_empty", exp_q.size(), 0);

      // random keys, fixed sector, 4 blocks encrypt
      k1 = rnd256(); k2 = rnd256();
      for (int i = 0; i < 4; i++) begin blk[i] = rnd256()[127:0]; pt[i] = blk[i]; end
      clear_log();
      push_exp(0, 64'h0123456789abcdef, 4, 4, k1, k2, 0, '0);
      run_cmd(0, 64'h0123456789abcdef, 4, k1, k2);
      @(posedge clk);
      check("enc_starts", starts, 5);
      check("enc_twk_key", st_key[0], k2);
      check("enc_twk_data", st_data[0], 128'hefcdab8967452301_0000000000000000);
      check("enc_blk_key", st_key[1], k1);
      check("enc_q_empty", exp_q.size(), 0);

      // decrypt that ciphertext with a stalling sink: plaintext must come back
      for (int i = 0; i < 4; i++) begin blk[i] = res[i]; exp_q.push_back(pt[i]); end
      clear_log();
      rdy_rand = 1;
      run_cmd(1, 64'h0123456789abcdef, 4, k1, k2);
      rdy_rand = 0;
      @(posedge clk);
      check("dec_twk_en", st_en[0], 1);
      check("dec_blk_en", st_en[1], 0);
      check("dec_q_empty", exp_q.size(), 0);

      // tweak wrap: T = LE byte15 0x80 -> next T = byte0 0x87
      for (int i = 0; i < 2; i++) blk[i] = '0;
      clear_log();
      force_val = 128'h80;
      force_twk = 1;
      push_exp(0, 64'd1, 2, 2, k1, k2, 1, 128'h80);
      run_cmd(0, 64'd1, 2, k1, k2);
      @(posedge clk);
      check("wrap_t0", st_data[1], 128'h80);
      check("wrap_t1", st_data[2], {8'h87, 120'h0});
      check("wrap_q_empty", exp_q.size(), 0);

      // abort in BLK_WAIT of block 2 of 4
      k1 = rnd256(); k2 = rnd256();
      for (int i = 0; i < 4; i++) blk[i] = rnd256()[127:0];
      clear_log();
      push_exp(0, 64'h77, 4, 1, k1, k2, 0, '0);
      @(posedge clk);
      d0 = done_cnt;
      send_cmd(0, 64'h77, 4, k1, k2);
      feed_one(blk[0]);
      feed_one(blk[1]);
      @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("abort_drain_busy", cmd_ready, 0);
      check("abort_drain_no_in", in_ready, 0);
      repeat (10) @(negedge clk);
      check("abort_idle", cmd_ready, 1);
      @(posedge clk);
      check("abort_no_done", done_cnt, d0);
      check("abort_q_empty", exp_q.size(), 0);

      // following command is unaffected
      for (int i = 0; i < 2; i++) blk[i] = rnd256()[127:0];
      push_exp(0, 64'h9abc, 2, 2, k1, k2, 0, '0);
      run_cmd(0, 64'h9abc, 2, k1, k2);
      @(posedge clk);
      check("post_abort_q_empty", exp_q.size(), 0);

      // core never answers: watchdog
      mute = 1;
      clear_log();
      @(posedge clk);
      d0 = done_cnt;
      e0 = err_cnt;
      send_cmd(0, 64'h42, 1, k1, k2);
      b = 0;
      while (!err && b < 60) begin @(negedge clk); b++; end
      if (b >= 60) tmo("wd_err_wait");
      check("wd_delay", cyc - last_start_cyc, 15);
      check("wd_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      check("wd_err_pulse", err, 0);
      @(posedge clk);
      check("wd_err_cnt", err_cnt, e0 + 1);
      check("wd_no_done", done_cnt, d0);
      mute = 0;

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
